// File: rtl/wishbone_reg_responder_if.sv
// Wishbone slave-side bus bundle for the register responder.
// The responder uses the slave modport. A bus master or testbench uses the master modport.
interface wishbone_reg_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_we_i,
    input  wbs_adr_i,
    input  wbs_dat_i,
    input  wbs_sel_i,
    output wbs_ack_o,
    output wbs_dat_o
  );

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_we_i,
    output wbs_adr_i,
    output wbs_dat_i,
    output wbs_sel_i,
    input  wbs_ack_o,
    input  wbs_dat_o
  );
endinterface

// File: rtl/wishbone_reg_responder.sv
// Wishbone register responder.
// - A 64 KB window at BASE_ADDR[31:16] holds NUM_REGS 32-bit registers.
// - Register 0 is read-only and returns status_i. Registers 1..NUM_REGS-1 are read/write with byte enables.
// - Each access is acked once, WAIT_STATES cycles after the minimum latency.
// - A write commits on the same edge that raises ack. That edge also drives a one-cycle wr_pulse_o for the target register.
module wishbone_reg_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  wishbone_reg_responder_if.slave  wb,
  input  logic [31:0]              status_i,
  output logic [NUM_REGS*32-1:0]   ctrl_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic                 we_reg;
  logic [31:2]          adr_reg;
  logic [31:0]          dat_reg;
  logic [3:0]           sel_reg;
  logic                 ack_reg;
  logic [31:0]          rdat_reg;
  logic [NUM_REGS-1:0]  pulse_reg;
  logic [31:0]          regs_reg [1:NUM_REGS-1];

  logic                 req;
  logic                 txn_we;
  logic [31:2]          txn_adr;
  logic [31:0]          txn_dat;
  logic [3:0]           txn_sel;
  logic                 txn_hit;
  logic [IDX_W-1:0]     txn_idx;
  logic                 enter_ack;
  logic                 commit;
  logic [31:0]          rdat_next;
  logic [NUM_REGS-1:0]  pulse_next;
  logic                 unused_adr_lsb;

  assign req = wb.wbs_cyc_i & wb.wbs_stb_i;

  // Byte offset within a word carries no meaning here.
  assign unused_adr_lsb = ^wb.wbs_adr_i[1:0];

  // Transaction being serviced.
  // - In IDLE it is the live bus request, so a zero-wait access can commit on its accepting edge.
  // - Otherwise it is the latched copy, so later bus changes cannot disturb it.
  always_comb begin
    txn_we  = we_reg;
    txn_adr = adr_reg;
    txn_dat = dat_reg;
    txn_sel = sel_reg;
    if (state_reg == IDLE) begin
      txn_we  = wb.wbs_we_i;
      txn_adr = wb.wbs_adr_i[31:2];
      txn_dat = wb.wbs_dat_i;
      txn_sel = wb.wbs_sel_i;
    end
  end

  // A hit needs the right 64 KB window and every address bit above the index cleared.
  assign txn_hit = (txn_adr[31:16] == BASE_ADDR[31:16]) &&
                   (txn_adr[15:2+IDX_W] == '0);
  assign txn_idx = txn_adr[2 +: IDX_W];

  assign enter_ack = ((state_reg == IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state_reg == WAIT) && req && (cnt_reg == 4'd0));

  assign commit = enter_ack && txn_we && txn_hit && (txn_idx != '0);

  // Read data mux.
  // - Register 0 returns the live status input.
  // - Misses and writes return 0.
  always_comb begin
    rdat_next = 32'h0;
    if (txn_hit && !txn_we) begin
      if (txn_idx == '0) begin
        rdat_next = status_i;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (txn_idx == IDX_W'(i)) begin
            rdat_next = regs_reg[i];
          end
        end
      end
    end
  end

  // One-hot commit strobe. Index 0 can never fire because commit excludes it.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pulse
      assign pulse_next[gi] = commit && (txn_idx == IDX_W'(gi));
    end
  endgenerate

  // Handshake FSM. Ack, read data and write pulse are registered and last only for the ACK cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= 32'h0;
      sel_reg   <= 4'h0;
      ack_reg   <= 1'b0;
      rdat_reg  <= 32'h0;
      pulse_reg <= '0;
    end else begin
      ack_reg   <= enter_ack;
      rdat_reg  <= enter_ack ? rdat_next : 32'h0;
      pulse_reg <= pulse_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg  <= wb.wbs_we_i;
            adr_reg <= wb.wbs_adr_i[31:2];
            dat_reg <= wb.wbs_dat_i;
            sel_reg <= wb.wbs_sel_i;
            if (WAIT_STATES == 0) begin
              state_reg <= ACK;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          // A dropped request abandons the access before any commit.
          if (!req) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ACK;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Register file. Write data is merged byte-by-byte under sel on the edge entering ACK.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_reg[i] <= 32'h0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (commit && (txn_idx == IDX_W'(i)) && txn_sel[j]) begin
            regs_reg[i][8*j +: 8] <= txn_dat[8*j +: 8];
          end
        end
      end
    end
  end

  assign ctrl_o[31:0] = 32'h0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_ctrl
      assign ctrl_o[gi*32 +: 32] = regs_reg[gi];
    end
  endgenerate

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = rdat_reg;
  assign wr_pulse_o   = pulse_reg;

endmodule

// File: tb/tb_wishbone_reg_responder.sv
// Testbench for wishbone_reg_responder.
// - dut uses WAIT_STATES=2.
// - dut0 uses WAIT_STATES=0 and is driven with back-to-back writes.
module tb_wishbone_reg_responder;
  localparam int NR = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             nRST;
  logic [31:0]      status;
  logic [NR*32-1:0] ctrl, ctrl0;
  logic [NR-1:0]    pulse, pulse0;

  wishbone_reg_responder_if wb();
  wishbone_reg_responder_if wb0();

  wishbone_reg_responder #(.BASE_ADDR(32'h3001_0000), .NUM_REGS(NR), .WAIT_STATES(2)) dut (
    .CLK(CLK), .nRST(nRST), .wb(wb), .status_i(status), .ctrl_o(ctrl), .wr_pulse_o(pulse));

  wishbone_reg_responder #(.BASE_ADDR(32'h3001_0000), .NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .wb(wb0), .status_i(status), .ctrl_o(ctrl0), .wr_pulse_o(pulse0));

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl  [NR];
  logic [31:0] mdl0 [NR];

  typedef struct {
    logic             chk_rdat;
    logic [31:0]      rdat;
    logic [NR-1:0]    pulse;
    logic [NR*32-1:0] ctrl;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] st;
  } vec_t;

  function automatic logic [NR*32-1:0] pack_mdl();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic logic [NR*32-1:0] pack_mdl0();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = mdl0[i];
    return v;
  endfunction

  // Expected outcome of one access to the 8-register window at 0x3001_0000; updates the model.
  function automatic exp_t predict(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                   input logic [3:0] sel, input logic [31:0] st);
    exp_t e;
    logic hit;
    logic [2:0] idx;
    hit = (adr[31:16] == 16'h3001) && (adr[15:5] == 11'd0);
    idx = adr[4:2];
    e.chk_rdat = !we;
    e.rdat = 32'h0;
    e.pulse = '0;
    if (hit && !we) e.rdat = (idx == 3'd0) ? st : mdl[idx];
    if (hit && we && idx != 3'd0) begin
      for (int j = 0; j < 4; j++) if (sel[j]) mdl[idx][8*j +: 8] = dat[8*j +: 8];
      e.pulse[idx] = 1'b1;
    end
    e.ctrl = pack_mdl();
    return e;
  endfunction

  function automatic exp_t predict0(input logic [2:0] idx, input logic [31:0] dat, input logic [3:0] sel);
    exp_t e;
    for (int j = 0; j < 4; j++) if (sel[j]) mdl0[idx][8*j +: 8] = dat[8*j +: 8];
    e.chk_rdat = 1'b0;
    e.rdat = 32'h0;
    e.pulse = '0;
    e.pulse[idx] = 1'b1;
    e.ctrl = pack_mdl0();
    return e;
  endfunction

  // Runs one access on dut starting at a negedge and returns what was observed.
  // Bus inputs other than cyc/stb are scrambled while waiting.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      output int lat, output logic [31:0] rdat, output logic [NR-1:0] pls,
                      output logic [NR*32-1:0] ctl, output int nz, output logic ack_after,
                      output logic [31:0] dat_after, output logic [NR-1:0] pls_after);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    lat = -1; nz = 0; rdat = '0; pls = '0; ctl = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (wb.wbs_ack_o === 1'b1) begin
        lat = n; rdat = wb.wbs_dat_o; pls = pulse; ctl = ctrl;
        break;
      end
      if (wb.wbs_dat_o !== 32'h0 || pulse !== '0) nz++;
      wb.wbs_we_i  = 1'($urandom_range(1));
      wb.wbs_adr_i = $urandom;
      wb.wbs_dat_i = $urandom;
      wb.wbs_sel_i = 4'($urandom_range(15));
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(negedge CLK);
    ack_after = wb.wbs_ack_o;
    dat_after = wb.wbs_dat_o;
    pls_after = pulse;
  endtask

  task automatic test_reset();
    int lat, nz;
    logic [31:0] rdat, dat_after;
    logic [NR-1:0] pls, pls_after;
    logic [NR*32-1:0] ctl;
    logic ack_after;
    exp_t e;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (wb.wbs_ack_o !== 1'b0 || wb0.wbs_ack_o !== 1'b0) begin errors++;
      $display("FAIL reset_ack got=%b/%b exp=0/0", wb.wbs_ack_o, wb0.wbs_ack_o); end
    checks++; if (wb.wbs_dat_o !== 32'h0 || wb0.wbs_dat_o !== 32'h0) begin errors++;
      $display("FAIL reset_dat got=%h/%h exp=0", wb.wbs_dat_o, wb0.wbs_dat_o); end
    checks++; if (ctrl !== '0 || ctrl0 !== '0) begin errors++;
      $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    checks++; if (pulse !== '0 || pulse0 !== '0) begin errors++;
      $display("FAIL reset_pulse got=%h/%h exp=0", pulse, pulse0); end
    $display("reset: ack=%b dat=%h ctrl_zero=%b", wb.wbs_ack_o, wb.wbs_dat_o, ctrl == '0);
    // Request issued together with reset release must be taken on the first edge.
    nRST = 1'b1;
    sb.push_back(predict(1'b0, 32'h3001_0008, 32'h0, 4'hF, status));
    xfer(1'b0, 32'h3001_0008, 32'h0, 4'hF, lat, rdat, pls, ctl, nz, ack_after, dat_after, pls_after);
    e = sb.pop_front();
    $display("first_after_reset: lat=%0d rdat=%h", lat, rdat);
    checks++; if (lat !== 3) begin errors++;
      $display("FAIL first_req_latency got=%0d exp=3", lat); end
    checks++; if (rdat !== e.rdat) begin errors++;
      $display("FAIL first_req_rdat got=%h exp=%h", rdat, e.rdat); end
  endtask

  task automatic test_reg_access();
    vec_t tbl [12];
    int lat, nz;
    logic [31:0] rdat, dat_after;
    logic [NR-1:0] pls, pls_after;
    logic [NR*32-1:0] ctl;
    logic ack_after;
    exp_t e;
    tbl = '{
      '{1'b1, 32'h3001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0},
      '{1'b1, 32'h3001_0004, 32'h1122_3344, 4'b0101, 32'h0},
      '{1'b0, 32'h3001_0004, 32'h0, 4'h0, 32'h0},
      '{1'b1, 32'h3001_001C, 32'h0A0B_0C0D, 4'b1001, 32'h0},
      '{1'b0, 32'h3001_001F, 32'h0, 4'hF, 32'h0},
      '{1'b0, 32'h3001_0000, 32'h0, 4'hF, 32'hCAFE_0001},
      '{1'b1, 32'h3001_0000, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678},
      '{1'b0, 32'h3002_0000, 32'h0, 4'hF, 32'h5555_AAAA},
      '{1'b0, 32'h3001_0040, 32'h0, 4'hF, 32'h5555_AAAA},
      '{1'b1, 32'h3001_0040, 32'h1234_5678, 4'hF, 32'h0},
      '{1'b1, 32'h3001_0024, 32'h55AA_55AA, 4'hF, 32'h0},
      '{1'b0, 32'h3001_0004, 32'h0, 4'hF, 32'h0}
    };
    for (int i = 0; i < 12; i++) begin
      status = tbl[i].st;
      sb.push_back(predict(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].st));
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, lat, rdat, pls, ctl, nz, ack_after, dat_after, pls_after);
      e = sb.pop_front();
      $display("acc[%0d]: we=%b adr=%h dat=%h sel=%h lat=%0d rdat=%h pulse=%h",
               i, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, lat, rdat, pls);
      checks++; if (lat !== 3) begin errors++;
        $display("FAIL acc%0d_latency got=%0d exp=3", i, lat); end
      checks++; if (pls !== e.pulse) begin errors++;
        $display("FAIL acc%0d_pulse got=%h exp=%h", i, pls, e.pulse); end
      checks++; if (ctl !== e.ctrl) begin errors++;
        $display("FAIL acc%0d_ctrl got=%h exp=%h", i, ctl, e.ctrl); end
      if (e.chk_rdat) begin
        checks++; if (rdat !== e.rdat) begin errors++;
          $display("FAIL acc%0d_rdat got=%h exp=%h", i, rdat, e.rdat); end
      end
      checks++; if (nz !== 0) begin errors++;
        $display("FAIL acc%0d_idle_before_ack got=%0d nonzero cycles exp=0", i, nz); end
      checks++; if (ack_after !== 1'b0 || dat_after !== 32'h0 || pls_after !== '0) begin errors++;
        $display("FAIL acc%0d_after_ack got ack=%b dat=%h pulse=%h exp=0/0/0", i, ack_after, dat_after, pls_after); end
    end
  endtask

  task automatic test_abort();
    int acks, pulses, lat, nz;
    logic [31:0] rdat, dat_after;
    logic [NR-1:0] pls, pls_after;
    logic [NR*32-1:0] ctl;
    logic ack_after;
    exp_t e;
    for (int drop = 1; drop <= 2; drop++) begin
      acks = 0; pulses = 0;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
      wb.wbs_adr_i = 32'h3001_000C; wb.wbs_dat_i = 32'hAAAA_5555; wb.wbs_sel_i = 4'hF;
      for (int c = 0; c < drop; c++) begin
        @(negedge CLK);
        if (wb.wbs_ack_o === 1'b1) acks++;
        if (pulse !== '0) pulses++;
      end
      if (drop == 1) wb.wbs_stb_i = 1'b0; else wb.wbs_cyc_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge CLK);
        if (wb.wbs_ack_o === 1'b1) acks++;
        if (pulse !== '0) pulses++;
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
      $display("abort[%0d]: acks=%0d pulses=%0d", drop, acks, pulses);
      checks++; if (acks !== 0) begin errors++;
        $display("FAIL abort%0d_ack got=%0d exp=0", drop, acks); end
      checks++; if (pulses !== 0) begin errors++;
        $display("FAIL abort%0d_pulse got=%0d exp=0", drop, pulses); end
      checks++; if (ctrl !== pack_mdl()) begin errors++;
        $display("FAIL abort%0d_ctrl got=%h exp=%h", drop, ctrl, pack_mdl()); end
      sb.push_back(predict(1'b0, 32'h3001_000C, 32'h0, 4'hF, status));
      xfer(1'b0, 32'h3001_000C, 32'h0, 4'hF, lat, rdat, pls, ctl, nz, ack_after, dat_after, pls_after);
      e = sb.pop_front();
      $display("after_abort[%0d]: lat=%0d rdat=%h", drop, lat, rdat);
      checks++; if (lat !== 3 || rdat !== e.rdat) begin errors++;
        $display("FAIL abort%0d_followup got lat=%0d rdat=%h exp lat=3 rdat=%h", drop, lat, rdat, e.rdat); end
    end
  endtask

  task automatic test_reset_mid();
    int acks, pulses;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = 32'h3001_0014; wb.wbs_dat_i = 32'h1234_5678; wb.wbs_sel_i = 4'hF;
    @(negedge CLK);
    nRST = 1'b0;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < NR; i++) begin mdl[i] = 32'h0; mdl0[i] = 32'h0; end
    acks = 0; pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (wb.wbs_ack_o === 1'b1) acks++;
      if (pulse !== '0) pulses++;
    end
    $display("reset_mid: acks=%0d pulses=%0d ctrl_zero=%b", acks, pulses, ctrl == '0);
    checks++; if (acks !== 0) begin errors++;
      $display("FAIL reset_mid_ack got=%0d exp=0", acks); end
    checks++; if (pulses !== 0) begin errors++;
      $display("FAIL reset_mid_pulse got=%0d exp=0", pulses); end
    checks++; if (ctrl !== pack_mdl()) begin errors++;
      $display("FAIL reset_mid_ctrl got=%h exp=%h", ctrl, pack_mdl()); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  idx_t [4];
    logic [31:0] dat_t [4];
    logic [3:0]  sel_t [4];
    int nxt, pcount;
    logic exp_ack;
    exp_t e;
    idx_t = '{3'd1, 3'd2, 3'd3, 3'd1};
    dat_t = '{32'h0102_0304, 32'hA5A5_5A5A, 32'hFEDC_BA98, 32'h7777_7777};
    sel_t = '{4'hF, 4'h3, 4'hC, 4'h2};
    pcount = 0;
    wb0.wbs_cyc_i = 1'b1; wb0.wbs_stb_i = 1'b1; wb0.wbs_we_i = 1'b1;
    wb0.wbs_adr_i = 32'h3001_0000 | {27'd0, idx_t[0], 2'b00};
    wb0.wbs_dat_i = dat_t[0]; wb0.wbs_sel_i = sel_t[0];
    sb.push_back(predict0(idx_t[0], dat_t[0], sel_t[0]));
    nxt = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      exp_ack = (c % 2 == 1) && (c <= 8);
      if (pulse0 !== '0) pcount++;
      $display("b2b cycle %0d: ack=%b pulse=%h", c, wb0.wbs_ack_o, pulse0);
      checks++; if (wb0.wbs_ack_o !== exp_ack) begin errors++;
        $display("FAIL b2b_ack_c%0d got=%b exp=%b", c, wb0.wbs_ack_o, exp_ack); end
      if (wb0.wbs_ack_o === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_ack_c%0d got=ack exp=none", c);
        end else begin
          e = sb.pop_front();
          checks++; if (pulse0 !== e.pulse) begin errors++;
            $display("FAIL b2b_pulse_c%0d got=%h exp=%h", c, pulse0, e.pulse); end
          checks++; if (ctrl0 !== e.ctrl) begin errors++;
            $display("FAIL b2b_ctrl_c%0d got=%h exp=%h", c, ctrl0, e.ctrl); end
        end
        if (nxt < 4) begin
          wb0.wbs_adr_i = 32'h3001_0000 | {27'd0, idx_t[nxt], 2'b00};
          wb0.wbs_dat_i = dat_t[nxt]; wb0.wbs_sel_i = sel_t[nxt];
          sb.push_back(predict0(idx_t[nxt], dat_t[nxt], sel_t[nxt]));
          nxt++;
        end else begin
          wb0.wbs_cyc_i = 1'b0; wb0.wbs_stb_i = 1'b0;
        end
      end
    end
    wb0.wbs_cyc_i = 1'b0; wb0.wbs_stb_i = 1'b0;
    checks++; if (pcount !== 4) begin errors++;
      $display("FAIL b2b_pulse_count got=%0d exp=4", pcount); end
    checks++; if (sb.size() !== 0) begin errors++;
      $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    status = 32'h0;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0; wb.wbs_sel_i = 4'h0;
    wb0.wbs_cyc_i = 1'b0; wb0.wbs_stb_i = 1'b0; wb0.wbs_we_i = 1'b0;
    wb0.wbs_adr_i = 32'h0; wb0.wbs_dat_i = 32'h0; wb0.wbs_sel_i = 4'h0;
    for (int i = 0; i < NR; i++) begin mdl[i] = 32'h0; mdl0[i] = 32'h0; end
    test_reset();
    test_reg_access();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wishbone_reg_responder.md
WISHBONE_REG_RESPONDER -- requirements
Module: wishbone_reg_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3001_0000; the responder's 64 KB window is selected by BASE_ADDR[31:16].
REQ-002 SHALL have parameter NUM_REGS, default 8; the number of 32-bit registers; power of two, 2..16.
REQ-003 SHALL have parameter WAIT_STATES, default 2; extra cycles before ack; legal range 0..15.
REQ-004 SHALL use one clock, CLK; reset nRST is synchronous and active-low.
REQ-005 SHALL have these ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte lane select
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- status_i  in  32  read-only value returned at register 0
- ctrl_o  out  NUM_REGS*32  packed register contents; slice i is register i; slice 0 is always 0
- wr_pulse_o  out  NUM_REGS  one-cycle write-commit strobe per register

Function
REQ-006 SHALL implement an FSM with states IDLE, WAIT and ACK.
REQ-007 In IDLE, with wbs_cyc_i=1 and wbs_stb_i=1 at a rising edge, SHALL latch we, adr, dat and sel.
- WAIT_STATES=0: go to ACK.
- Otherwise: go to WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-008 In WAIT, SHALL decrement the counter each cycle and go to ACK on the cycle after the counter reads 0.
REQ-009 wbs_ack_o SHALL be registered and high only in ACK, for exactly one cycle, in cycle k+1+WAIT_STATES, where k is the accepting edge.
REQ-010 ACK SHALL return unconditionally to IDLE; there is at least one idle cycle between transactions.
REQ-011 Hit SHALL be defined as adr[31:16]==BASE_ADDR[31:16] and adr[15:2+log2(NUM_REGS)]==0; the register index is adr[2+:log2(NUM_REGS)]; adr[1:0] is ignored.
REQ-012 A write hit to index i≥1 SHALL update each byte lane j where sel[j]=1 with dat[8j+7:8j]; lanes with sel[j]=0 SHALL keep their value.
REQ-013 The write SHALL commit on the edge that enters ACK, so that ctrl_o and wr_pulse_o[i] (high for that same single cycle) reflect it while ack is high.
REQ-014 A write to index 0, or any write miss, SHALL change no register and assert no wr_pulse_o bit, but SHALL still be acked.
REQ-015 Read data SHALL be captured on the edge entering ACK and presented on wbs_dat_o only while ack is high; wbs_dat_o SHALL be 0 at all other times.
- Index 0 returns status_i as sampled on that edge.
- Index i≥1 returns register i.
- A miss returns 32'h0.
- sel is ignored on reads.
REQ-016 If wbs_cyc_i or wbs_stb_i is low during WAIT, SHALL abort to IDLE with no write, no pulse and no ack.
REQ-017 Once in ACK, the transaction SHALL complete regardless of cyc/stb.
REQ-018 Inputs changing after acceptance SHALL NOT affect the latched transaction.
REQ-019 At most one wr_pulse_o bit SHALL be high in any cycle.

Reset
REQ-020 While nRST=0 at a rising edge, SHALL set: state IDLE, counter 0, wbs_ack_o=0, wbs_dat_o=0, all registers 0, wr_pulse_o=0.
REQ-021 Reset asserted mid-transaction SHALL discard that transaction: no commit and no ack after reset releases.
REQ-022 The first request SHALL be accepted on the first edge with nRST=1.

Verification
REQ-023 With WAIT_STATES=2, write 32'hDEADBEEF, sel=4'hF to 0x3001_0004 (accepted at edge k):
- ack high in cycle k+3 only.
- ctrl_o register 1 = DEADBEEF and wr_pulse_o=8'h02 in that same cycle.
REQ-024 Then write 32'h11223344, sel=4'b0101, to the same address, and read it back:
- Read returns 32'hDE22BE44; wbs_dat_o=0 outside the ack cycle.
REQ-025 Read of index 0 with status_i=32'hCAFE0001: returns CAFE0001. Write to index 0: acked, wr_pulse_o=0, all registers unchanged.
REQ-026 Read of 0x3002_0000 and of 0x3001_0040 (misses): each acked in cycle k+3 with data 0. Write to 0x3001_0040: no register change.
REQ-027 Drop stb during WAIT: no ack, no write; a subsequent request completes normally. Assert nRST=0 in WAIT: no ack after release, registers 0.
REQ-028 With WAIT_STATES=0, run back-to-back writes holding stb high: ack every other cycle (ACK, IDLE, ACK...), each write committed once.
